// File: rtl/magic_backend_types.sv
// Shared backend types: branch condition/kind encodings and the branch unit's pipeline payloads.
package magic_backend_types;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } br_ops;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2
  } br_kind_t;

  // Tags live outside these structs so the unit's tag widths stay parameterisable.
  typedef struct packed {
    br_kind_t          kind;
    br_ops             op;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
  } br_s1_t;

  typedef struct packed {
    logic              taken;
    logic              mispredict;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   data;
  } br_s2_t;

  function automatic logic [XLEN-1:0] link_addr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_check.sv
// Branch condition evaluator: combinational compare of two operands under a br_ops condition.
module branch_check
  import magic_backend_types::*;
(
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  br_ops           op_i,
  output logic            br_en_o
);

  always_comb begin
    br_en_o = 1'b0;
    case (op_i)
      beq:     br_en_o = (rs1_i == rs2_i);
      bne:     br_en_o = (rs1_i != rs2_i);
      blt:     br_en_o = ($signed(rs1_i) <  $signed(rs2_i));
      bge:     br_en_o = ($signed(rs1_i) >= $signed(rs2_i));
      bltu:    br_en_o = (rs1_i <  rs2_i);
      bgeu:    br_en_o = (rs1_i >= rs2_i);
      default: br_en_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: issue -> S1 (operands) -> S2 (resolved result) -> CDB, 2-cycle minimum latency, 1 op/cycle.
// S2 holds until granted; issue_ready drops only when both stages are full and the CDB does not grant.
module branch_unit
  import magic_backend_types::*;
#(
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  br_kind_t             issue_kind,
  input  br_ops                issue_br_op,
  input  logic [XLEN-1:0]      issue_rs1_v,
  input  logic [XLEN-1:0]      issue_rs2_v,
  input  logic [XLEN-1:0]      issue_pc,
  input  logic [XLEN-1:0]      issue_imm,
  input  logic                 issue_pred_taken,
  input  logic [XLEN-1:0]      issue_pred_target,
  input  logic [ROB_IDX_W-1:0] issue_rob_idx,
  input  logic [PREG_W-1:0]    issue_pd,
  output logic                 cdb_valid,
  input  logic                 cdb_ready,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [PREG_W-1:0]    cdb_pd,
  output logic [XLEN-1:0]      cdb_data,
  output logic                 cdb_taken,
  output logic [XLEN-1:0]      cdb_target,
  output logic                 cdb_mispredict
);

  br_s1_t                s1_q, s1_d;
  br_s2_t                s2_q, s2_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [ROB_IDX_W-1:0]  s1_rob_q, s2_rob_q;
  logic [PREG_W-1:0]     s1_pd_q, s2_pd_q;

  logic                  s2_adv;
  logic                  s1_load;
  logic                  s2_load;
  logic                  cond_taken;
  logic                  taken;
  logic [XLEN-1:0]       jump_tgt;
  logic [XLEN-1:0]       next_pc;

  assign s2_adv      = !s2_valid_q || cdb_ready;
  assign issue_ready = !s1_valid_q || s2_adv;
  assign s1_load     = issue_valid && issue_ready && !flush;
  assign s2_load     = s2_adv && s1_valid_q;

  always_comb begin
    s1_d             = '0;
    s1_d.kind        = issue_kind;
    s1_d.op          = issue_br_op;
    s1_d.rs1         = issue_rs1_v;
    s1_d.rs2         = issue_rs2_v;
    s1_d.pc          = issue_pc;
    s1_d.imm         = issue_imm;
    s1_d.pred_taken  = issue_pred_taken;
    s1_d.pred_target = issue_pred_target;
  end

  branch_check u_branch_check (
    .rs1_i   (s1_q.rs1),
    .rs2_i   (s1_q.rs2),
    .op_i    (s1_q.op),
    .br_en_o (cond_taken)
  );

  // Resolution from S1 contents; JALR clears bit 0 of the computed address.
  always_comb begin
    taken    = (s1_q.kind == BR_COND) ? cond_taken : 1'b1;
    jump_tgt = (s1_q.kind == BR_JALR) ? ((s1_q.rs1 + s1_q.imm) & ~32'h1)
                                      : (s1_q.pc + s1_q.imm);
    next_pc  = taken ? jump_tgt : link_addr(s1_q.pc);

    s2_d            = '0;
    s2_d.taken      = taken;
    s2_d.target     = next_pc;
    s2_d.data       = (s1_q.kind == BR_COND) ? '0 : link_addr(s1_q.pc);
    s2_d.mispredict = (taken != s1_q.pred_taken) ||
                      (taken && (next_pc != s1_q.pred_target));
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (issue_ready) begin
      s1_valid_d = issue_valid;
    end
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      s1_rob_q   <= '0;
      s2_rob_q   <= '0;
      s1_pd_q    <= '0;
      s2_pd_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_q     <= s1_d;
        s1_rob_q <= issue_rob_idx;
        s1_pd_q  <= issue_pd;
      end
      if (s2_load) begin
        s2_q     <= s2_d;
        s2_rob_q <= s1_rob_q;
        s2_pd_q  <= s1_pd_q;
      end
    end
  end

  // Outputs are forced to zero whenever nothing valid is presented.
  assign cdb_valid      = s2_valid_q;
  assign cdb_rob_idx    = s2_valid_q ? s2_rob_q        : '0;
  assign cdb_pd         = s2_valid_q ? s2_pd_q         : '0;
  assign cdb_data       = s2_valid_q ? s2_q.data       : '0;
  assign cdb_taken      = s2_valid_q & s2_q.taken;
  assign cdb_target     = s2_valid_q ? s2_q.target     : '0;
  assign cdb_mispredict = s2_valid_q & s2_q.mispredict;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: queue-based reference model, directed literal cases, random traffic.
module tb_branch_unit;
  import magic_backend_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  br_kind_t    issue_kind = BR_COND;
  br_ops       issue_br_op = beq;
  logic [31:0] issue_rs1_v = '0;
  logic [31:0] issue_rs2_v = '0;
  logic [31:0] issue_pc = '0;
  logic [31:0] issue_imm = '0;
  logic        issue_pred_taken = 1'b0;
  logic [31:0] issue_pred_target = '0;
  logic [4:0]  issue_rob_idx = '0;
  logic [5:0]  issue_pd = '0;
  logic        cdb_valid;
  logic        cdb_ready = 1'b0;
  logic [4:0]  cdb_rob_idx;
  logic [5:0]  cdb_pd;
  logic [31:0] cdb_data;
  logic        cdb_taken;
  logic [31:0] cdb_target;
  logic        cdb_mispredict;

  int checks = 0;
  int errors = 0;

  branch_unit #(.ROB_IDX_W(5), .PREG_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_kind        (issue_kind),
    .issue_br_op       (issue_br_op),
    .issue_rs1_v       (issue_rs1_v),
    .issue_rs2_v       (issue_rs2_v),
    .issue_pc          (issue_pc),
    .issue_imm         (issue_imm),
    .issue_pred_taken  (issue_pred_taken),
    .issue_pred_target (issue_pred_target),
    .issue_rob_idx     (issue_rob_idx),
    .issue_pd          (issue_pd),
    .cdb_valid         (cdb_valid),
    .cdb_ready         (cdb_ready),
    .cdb_rob_idx       (cdb_rob_idx),
    .cdb_pd            (cdb_pd),
    .cdb_data          (cdb_data),
    .cdb_taken         (cdb_taken),
    .cdb_target        (cdb_target),
    .cdb_mispredict    (cdb_mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  pd;
    logic [31:0] data;
    logic [31:0] target;
    logic        taken;
    logic        mis;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  int   edge_cnt = 0;
  bit   fire_issue = 0;
  bit   fire_cdb = 0;
  bit   fl = 0;

  function automatic exp_t predict();
    exp_t e;
    logic c;
    logic [31:0] a, b, t;
    a = issue_rs1_v;
    b = issue_rs2_v;
    case (issue_br_op)
      beq:     c = (a == b);
      bne:     c = (a != b);
      blt:     c = ($signed(a) < $signed(b));
      bge:     c = ($signed(a) >= $signed(b));
      bltu:    c = (a < b);
      bgeu:    c = (a >= b);
      default: c = 1'b0;
    endcase
    e.taken = (issue_kind == BR_COND) ? c : 1'b1;
    if (!e.taken)                   t = issue_pc + 32'd4;
    else if (issue_kind == BR_JALR) t = (a + issue_imm) & 32'hFFFF_FFFE;
    else                            t = issue_pc + issue_imm;
    e.target = t;
    e.data   = (issue_kind == BR_COND) ? 32'd0 : issue_pc + 32'd4;
    e.mis    = (e.taken != issue_pred_taken) || (e.taken && (t != issue_pred_target));
    e.rob    = issue_rob_idx;
    e.pd     = issue_pd;
    e.acc    = 0;
    return e;
  endfunction

  // An op accepted at edge N is visible from edge N+1 onward once it is the oldest in flight.
  always @(negedge clk) begin
    bit exp_v;
    bit exp_rdy;
    fire_issue = 0;
    fire_cdb   = 0;
    fl         = 0;
    if (!rst) begin
      exp_v   = (q.size() > 0) && (q[0].acc < edge_cnt);
      exp_rdy = (q.size() < 2) || cdb_ready;
      chk1("issue_ready", issue_ready, exp_rdy);
      chk1("cdb_valid", cdb_valid, exp_v);
      if (exp_v) begin
        chk32("cdb_rob_idx", 32'(cdb_rob_idx), 32'(q[0].rob));
        chk32("cdb_pd", 32'(cdb_pd), 32'(q[0].pd));
        chk32("cdb_data", cdb_data, q[0].data);
        chk32("cdb_target", cdb_target, q[0].target);
        chk1("cdb_taken", cdb_taken, q[0].taken);
        chk1("cdb_mispredict", cdb_mispredict, q[0].mis);
      end else begin
        chk32("idle_rob_idx", 32'(cdb_rob_idx), 32'd0);
        chk32("idle_pd", 32'(cdb_pd), 32'd0);
        chk32("idle_data", cdb_data, 32'd0);
        chk32("idle_target", cdb_target, 32'd0);
        chk1("idle_taken", cdb_taken, 1'b0);
        chk1("idle_mispredict", cdb_mispredict, 1'b0);
      end
      fire_issue = issue_valid && exp_rdy;
      fire_cdb   = exp_v && cdb_ready;
      fl         = flush;
      pend       = predict();
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      edge_cnt++;
      if (fl) begin
        q.delete();
      end else begin
        if (fire_cdb) void'(q.pop_front());
        if (fire_issue) begin
          pend.acc = edge_cnt;
          q.push_back(pend);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input br_kind_t k, input br_ops o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                        input logic [31:0] ptgt, input logic [4:0] rob, input logic [5:0] pd);
    issue_kind        = k;
    issue_br_op       = o;
    issue_rs1_v       = a;
    issue_rs2_v       = b;
    issue_pc          = pc;
    issue_imm         = imm;
    issue_pred_taken  = pt;
    issue_pred_target = ptgt;
    issue_rob_idx     = rob;
    issue_pd          = pd;
  endtask

  task automatic set_jal(input int i);
    set_op(BR_JAL, beq, 32'd0, 32'd0, 32'h1000 + 32'(i * 16), 32'h8, 1'b1,
           32'h1008 + 32'(i * 16), 5'(10 + i), 6'(1 + i));
  endtask

  // Presents the already-set op and returns at posedge+1 after it was accepted.
  task automatic drive_one();
    int n;
    bit done;
    n = 0;
    done = 0;
    issue_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (issue_ready) done = 1;
      else begin
        n++;
        if (n > 50) begin
          timeout("issue_accept");
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  task automatic grab(output int waited);
    bit done;
    waited = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      waited++;
      if (cdb_valid) done = 1;
      else if (waited > 50) begin
        timeout("cdb_wait");
        done = 1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int w;
    int acc;
    int ngot;
    logic [4:0] got_rob [8];
    logic [31:0] r;
    br_kind_t kinds [3];
    br_ops ops [6];
    kinds = '{BR_COND, BR_JAL, BR_JALR};
    ops   = '{beq, bne, blt, bge, bltu, bgeu};

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("reset_cdb_valid", cdb_valid, 1'b0);
    chk1("reset_issue_ready", issue_ready, 1'b1);
    chk32("reset_cdb_target", cdb_target, 32'd0);
    @(posedge clk);
    #1 cdb_ready = 1'b1;

    // beq taken, predicted correctly, 2-cycle latency
    set_op(BR_COND, beq, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120, 5'd1, 6'd0);
    drive_one();
    grab(w);
    chk32("beq_latency", 32'(w), 32'd2);
    chk1("beq_taken", cdb_taken, 1'b1);
    chk32("beq_target", cdb_target, 32'h120);
    chk1("beq_mispredict", cdb_mispredict, 1'b0);
    chk32("beq_data", cdb_data, 32'd0);
    @(posedge clk); #1;

    // blt signed: -1 < 1 is taken, predicted not-taken
    set_op(BR_COND, blt, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 32'h0, 5'd2, 6'd0);
    drive_one();
    grab(w);
    chk1("blt_taken", cdb_taken, 1'b1);
    chk32("blt_target", cdb_target, 32'h240);
    chk1("blt_mispredict", cdb_mispredict, 1'b1);
    @(posedge clk); #1;

    // bltu on the same operands is not taken
    set_op(BR_COND, bltu, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 32'h0, 5'd3, 6'd0);
    drive_one();
    grab(w);
    chk1("bltu_taken", cdb_taken, 1'b0);
    chk32("bltu_target", cdb_target, 32'h204);
    chk1("bltu_mispredict", cdb_mispredict, 1'b0);
    @(posedge clk); #1;

    // jalr clears bit 0, link wraps to 0
    set_op(BR_JALR, beq, 32'h2003, 32'd0, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'h2002, 5'd4, 6'd7);
    drive_one();
    grab(w);
    chk32("jalr_target", cdb_target, 32'h2002);
    chk32("jalr_data", cdb_data, 32'd0);
    chk32("jalr_pd", 32'(cdb_pd), 32'd7);
    chk1("jalr_mispredict", cdb_mispredict, 1'b0);
    @(posedge clk); #1;

    // backpressure: 4 back-to-back issues against a stalled CDB
    cdb_ready = 1'b0;
    acc = 0;
    ngot = 0;
    set_jal(0);
    issue_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (issue_valid && issue_ready) acc++;
      if (cdb_valid && cdb_ready && ngot < 8) begin
        got_rob[ngot] = cdb_rob_idx;
        ngot++;
      end
      if (t == 5) begin
        chk32("bp_accepts", 32'(acc), 32'd2);
        chk1("bp_issue_ready", issue_ready, 1'b0);
        chk32("bp_stall_rob", 32'(cdb_rob_idx), 32'd10);
      end
      @(posedge clk);
      #1;
      if (acc >= 4) issue_valid = 1'b0;
      else set_jal(acc);
      cdb_ready = (t >= 5);
    end
    chk32("bp_results", 32'(ngot), 32'd4);
    for (int i = 0; i < 4; i++) chk32("bp_order", 32'(got_rob[i]), 32'(10 + i));

    // flush with both stages full; issue in the flush cycle is dropped
    cdb_ready = 1'b0;
    set_jal(4);
    drive_one();
    set_jal(5);
    drive_one();
    flush = 1'b1;
    cdb_ready = 1'b1;
    set_jal(6);
    issue_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    chk1("flush_cdb_valid", cdb_valid, 1'b0);
    chk1("flush_issue_ready", issue_ready, 1'b1);
    @(negedge clk);
    chk1("flush_dropped_issue", cdb_valid, 1'b0);
    @(posedge clk); #1;

    // async reset pulse while stalled
    cdb_ready = 1'b0;
    set_jal(7);
    drive_one();
    set_jal(8);
    drive_one();
    @(negedge clk);
    chk1("stall_before_rst", cdb_valid, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk1("arst_cdb_valid", cdb_valid, 1'b0);
    chk32("arst_cdb_target", cdb_target, 32'd0);
    chk32("arst_cdb_rob", 32'(cdb_rob_idx), 32'd0);
    chk1("arst_issue_ready", issue_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_cdb_valid", cdb_valid, 1'b0);
    @(posedge clk); #1;

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      cdb_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      issue_kind  = kinds[$urandom_range(0, 2)];
      issue_br_op = ops[$urandom_range(0, 5)];
      issue_rs1_v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      issue_rs2_v = ($urandom_range(0, 3) == 0) ? issue_rs1_v : $urandom;
      issue_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      r           = $urandom;
      issue_imm   = {{20{r[11]}}, r[11:1], 1'b0};
      issue_pred_taken = r[12];
      case (r[14:13])
        2'd0:    issue_pred_target = issue_pc + issue_imm;
        2'd1:    issue_pred_target = (issue_rs1_v + issue_imm) & 32'hFFFF_FFFE;
        2'd2:    issue_pred_target = issue_pc + 32'd4;
        default: issue_pred_target = $urandom;
      endcase
      issue_rob_idx = r[20:16];
      issue_pd      = r[26:21];
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0;
    flush = 1'b0;
    cdb_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
